// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared definitions for the AXI-Stream unit arbiter:
//   - state_t      : sequencer states (idle / issue to unit / wait for result /
//                    return result to requester)
//   - DEF_*        : default parameter values for axis_unit_arbiter
//   - wrap_inc()   : modulo-n increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package axis_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DATA_W  = 2;
  localparam int DEF_RES_W   = 2;
  localparam int DEF_TIMEOUT = 64;

  // Returns (i + 1) mod n for 0 <= i < n.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage : axis_arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches valid[] starting at
// position ptr and wrapping modulo N; reports the first set position.
//
// Ports:
//   valid  in  N      request vector
//   ptr    in  IDX_W  highest-priority position this cycle (must be < N)
//   found  out 1      at least one valid bit is set
//   idx    out IDX_W  winning position (0 when found is 0)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Scan offsets from the far end back to offset 0 so that the closest
  // candidate to ptr is the last one written, and therefore the winner.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so that no
    // path leaves it unassigned, which would infer a latch.
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (valid[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule : rr_pick

// File: rtl/axis_unit_arbiter.sv
// -----------------------------------------------------------------------------
// axis_unit_arbiter
// Shares one AXI-Stream compute unit between N_REQ requester streams. One
// request is accepted at a time (round-robin), driven into the unit, and its
// result (or all-ones on a watchdog abort) is routed back to the requester
// that issued it. Only one unit transaction is ever outstanding.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   DATA_W   request payload width (unit s_tdata)
//   RES_W    result width (unit m_tdata)
//   TIMEOUT  max cycles spent waiting for a result before abort (>= 2)
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   req_tvalid/tdata      requester streams, requester i in slice i
//   req_tready            one-hot accept, only in IDLE
//   rsp_tvalid/tdata      one-hot result stream, non-granted slices are 0
//   rsp_tready            per-requester result ready (only granted one used)
//   u_s_tvalid/tdata      request stream to the unit
//   u_s_tready            unit accepts the request
//   u_m_tvalid/tdata      result stream from the unit
//   u_m_tready            arbiter accepts the result (high in WAIT)
//   busy                  sequencer not idle
//   grant_id              current / last granted requester
//   timeout_err           one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module axis_unit_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int IDX_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [N_REQ-1:0]        req_tvalid,
  input  logic [N_REQ*DATA_W-1:0] req_tdata,
  output logic [N_REQ-1:0]        req_tready,

  output logic [N_REQ-1:0]        rsp_tvalid,
  output logic [N_REQ*RES_W-1:0]  rsp_tdata,
  input  logic [N_REQ-1:0]        rsp_tready,

  output logic                    u_s_tvalid,
  output logic [DATA_W-1:0]       u_s_tdata,
  input  logic                    u_s_tready,

  input  logic                    u_m_tvalid,
  input  logic [RES_W-1:0]        u_m_tdata,
  output logic                    u_m_tready,

  output logic                    busy,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant_q;
  logic [DATA_W-1:0] pay_q;
  logic [RES_W-1:0]  res_q;
  logic [TMR_W-1:0]  timer;
  logic              to_q;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_data;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid (req_tvalid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Payload of the current round-robin winner.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_data = req_tdata[i*DATA_W +: DATA_W];
    end
  end

  // Sequencer, watchdog and data latches.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      grant_q <= '0;
      pay_q   <= '0;
      res_q   <= '0;
      timer   <= '0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            pay_q   <= pick_data;
            grant_q <= pick_idx;
            ptr     <= IDX_W'(wrap_inc(int'(pick_idx), N_REQ));
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The watchdog only covers the result phase; a unit stalling its
          // input does not count against it.
          if (u_s_tready) begin
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A result arriving in the last allowed cycle still wins.
          if (u_m_tvalid) begin
            res_q <= u_m_tdata;
            state <= S_RETURN;
          end else if (timer == TMR_LAST) begin
            res_q <= '1;
            to_q  <= 1'b1;
            state <= S_RETURN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RETURN: begin
          if (rsp_tready[grant_q]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Ready to requesters: only the winner, only in IDLE. Gated by reset so
  // nothing is accepted while the block is held in reset.
  always_comb begin
    req_tready = '0;
    if (state == S_IDLE && pick_found && !reset) begin
      req_tready = N_REQ'(1) << pick_idx;
    end
  end

  // Result routing: only the granted slice carries data.
  always_comb begin
    rsp_tvalid = '0;
    rsp_tdata  = '0;
    if (state == S_RETURN) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_q == IDX_W'(i)) begin
          rsp_tvalid[i]                = 1'b1;
          rsp_tdata[i*RES_W +: RES_W] = res_q;
        end
      end
    end
  end

  assign u_s_tvalid  = (state == S_ISSUE);
  assign u_s_tdata   = pay_q;
  assign u_m_tready  = (state == S_WAIT);
  assign busy        = (state != S_IDLE);
  assign grant_id    = grant_q;
  assign timeout_err = to_q;

endmodule : axis_unit_arbiter
